// File: rtl/ifetch_queue.sv
// Instruction queue between fetch and decode: buffers {instr, pc, adel} and presents the head to ID.
// Optional macro IFQ_BYPASS_EN lets a word arriving at an empty queue reach decode in the same cycle.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_adel,
  input  logic             flush,
  input  logic             id_accept,
  output logic [31:0]      instrD,
  output logic [31:0]      pcD,
  output logic             adelD,
  output logic             validD,
  output logic             stallD,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic             r_adel  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_byp_take;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_FULL);

`ifdef IFQ_BYPASS_EN
  // A word presented to an empty queue is shown to decode directly; if decode
  // takes it in the same cycle it is never written.
  assign w_byp      = w_empty & in_valid & ~flush;
  assign w_byp_take = w_byp & id_accept;
`else
  assign w_byp      = 1'b0;
  assign w_byp_take = 1'b0;
`endif

  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full & ~flush & ~w_byp_take;
  assign w_pop    = id_accept & ~w_empty & ~flush;
  assign count    = r_count;

  always_comb begin
    instrD = 32'h0;
    pcD    = 32'h0;
    adelD  = 1'b0;
    validD = 1'b0;
    if (!w_empty) begin
      instrD = r_instr[r_rd_ptr];
      pcD    = r_pc[r_rd_ptr];
      adelD  = r_adel[r_rd_ptr];
      validD = 1'b1;
    end else if (w_byp) begin
      instrD = in_instr;
      pcD    = in_pc;
      adelD  = in_adel;
      validD = 1'b1;
    end
  end

  assign stallD = ~validD;

  // Control state: flush outranks push and pop and empties the queue at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= in_instr;
      r_pc[r_wr_ptr]    <= in_pc;
      r_adel[r_wr_ptr]  <= in_adel;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand-written corner sequences, random traffic vs a queue scoreboard.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_adel = 1'b0;
  logic        flush = 1'b0;
  logic        id_accept = 1'b0;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        adelD;
  logic        validD;
  logic        stallD;
  logic [PTR_W:0] count;

  ifetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_adel(in_adel), .flush(flush),
    .id_accept(id_accept), .instrD(instrD), .pcD(pcD), .adelD(adelD),
    .validD(validD), .stallD(stallD), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ad;
  } ent_t;

  typedef struct {
    logic        vld;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ad;
    logic        fl;
    logic        acc;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic        e_rdy;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic        e_ad;
  } vec_t;

  ent_t q[$];
  vec_t tab[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   seen_flushed = 1'b0;

  function automatic vec_t mk(logic vld, logic [31:0] ins, logic [31:0] pc, logic ad, logic fl,
                              logic acc, logic [2:0] e_cnt, logic e_vld, logic e_rdy,
                              logic [31:0] e_ins, logic [31:0] e_pc, logic e_ad);
    vec_t v;
    v.vld = vld; v.ins = ins; v.pc = pc; v.ad = ad; v.fl = fl; v.acc = acc;
    v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_ins = e_ins; v.e_pc = e_pc; v.e_ad = e_ad;
    return v;
  endfunction

  function automatic logic [70:0] obs();
    return {count, validD, stallD, in_ready, instrD, pcD, adelD};
  endfunction

  task automatic cmp(input string nm, input logic [70:0] act, input logic [70:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h ({count,validD,stallD,in_ready,instrD,pcD,adelD})", nm, act, exp);
    end
  endtask

  task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ad, input logic fl, input logic acc);
    in_valid = v; in_instr = ins; in_pc = p; in_adel = ad; flush = fl; id_accept = acc;
  endtask

  // Compare DUT against the scoreboard head, then apply this cycle's handshakes to the model.
  task automatic sb_check_update(input string nm);
    logic [70:0] e;
    bit          rdy;
    ent_t        n;
    rdy = (q.size() != DEPTH);
    if (q.size() != 0)
      e = {3'(q.size()), 1'b1, 1'b0, rdy, q[0].ins, q[0].pc, q[0].ad};
    else
      e = {3'd0, 1'b0, 1'b1, rdy, 32'h0, 32'h0, 1'b0};
    cmp(nm, obs(), e);
    if (flush) q.delete();
    else begin
      if (id_accept && q.size() != 0) void'(q.pop_front());
      if (in_valid && rdy) begin
        n.ins = in_instr; n.pc = in_pc; n.ad = in_adel;
        q.push_back(n);
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic ad, input logic fl, input logic acc, input string nm);
    @(negedge clk);
    drive(v, ins, p, ad, fl, acc);
    #1;
    sb_check_update(nm);
  endtask

  always @(negedge clk) begin
    if (resetn && validD && pcD == 32'hBFC00100) seen_flushed = 1'b1;
    if (resetn) begin
      n_vec++;
      if (count > DEPTH) begin
        n_err++;
        $display("FAIL count_bound: got %0d want <= %0d", count, DEPTH);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [70:0] e;
    // Directed table: inputs for a cycle and the outputs expected during that cycle.
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));
    tab.push_back(mk(1, 32'h3C011234, 32'hBFC00000, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));
    tab.push_back(mk(1, 32'h34210001, 32'hBFC00004, 0, 0, 0, 1, 1, 1, 32'h3C011234, 32'hBFC00000, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 2, 1, 1, 32'h3C011234, 32'hBFC00000, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 1, 2, 1, 1, 32'h3C011234, 32'hBFC00000, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 1, 32'h34210001, 32'hBFC00004, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 1, 1, 1, 1, 32'h34210001, 32'hBFC00004, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));
    tab.push_back(mk(1, 32'h20000000, 32'hBFC00010, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));
    tab.push_back(mk(1, 32'h20000001, 32'hBFC00014, 0, 0, 0, 1, 1, 1, 32'h20000000, 32'hBFC00010, 0));
    tab.push_back(mk(1, 32'h20000002, 32'hBFC00018, 0, 0, 0, 2, 1, 1, 32'h20000000, 32'hBFC00010, 0));
    tab.push_back(mk(1, 32'h20000003, 32'hBFC0001C, 0, 0, 0, 3, 1, 1, 32'h20000000, 32'hBFC00010, 0));
    tab.push_back(mk(1, 32'h20000004, 32'hBFC00020, 0, 0, 0, 4, 1, 0, 32'h20000000, 32'hBFC00010, 0));
    tab.push_back(mk(1, 32'h20000004, 32'hBFC00020, 0, 0, 1, 4, 1, 0, 32'h20000000, 32'hBFC00010, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 3, 1, 1, 32'h20000001, 32'hBFC00014, 0));
    tab.push_back(mk(1, 32'h11111111, 32'hBFC00100, 0, 1, 0, 3, 1, 1, 32'h20000001, 32'hBFC00014, 0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));
    tab.push_back(mk(1, 32'hDEADBEEF, 32'hBFC00002, 1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 1, 32'hDEADBEEF, 32'hBFC00002, 1));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 1, 1, 1, 1, 32'hDEADBEEF, 32'hBFC00002, 1));
    tab.push_back(mk(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0));

    repeat (2) @(negedge clk);
    #1;
    cmp("in_reset", obs(), {3'd0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0});
    @(negedge clk);
    resetn = 1'b1;

    foreach (tab[i]) begin
      @(negedge clk);
      drive(tab[i].vld, tab[i].ins, tab[i].pc, tab[i].ad, tab[i].fl, tab[i].acc);
      #1;
      e = {tab[i].e_cnt, tab[i].e_vld, ~tab[i].e_vld, tab[i].e_rdy, tab[i].e_ins, tab[i].e_pc, tab[i].e_ad};
      cmp($sformatf("tab%0d", i), obs(), e);
      sb_check_update($sformatf("sb_tab%0d", i));
    end

    // Streaming at occupancy 2: every cycle one in, one out, across pointer wrap.
    step(1, 32'h30000000, 32'hBFC00200, 0, 0, 0, "stream_fill0");
    step(1, 32'h30000001, 32'hBFC00204, 0, 0, 0, "stream_fill1");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 32'h30000002 + 32'(i), 32'hBFC00208 + 32'(4*i), 0, 0, 1);
      #1;
      cmp32($sformatf("stream_pc%0d", i), pcD, 32'hBFC00200 + 32'(4*i));
      cmp32($sformatf("stream_cnt%0d", i), 32'(count), 32'd2);
      sb_check_update($sformatf("sb_stream%0d", i));
    end
    step(0, 0, 0, 0, 0, 1, "stream_drain0");
    step(0, 0, 0, 0, 0, 1, "stream_drain1");
    step(0, 0, 0, 0, 0, 0, "stream_empty");

    // Asynchronous reset in the middle of a cycle with three entries held.
    step(1, 32'h40000000, 32'hBFC00300, 0, 0, 0, "rst_fill0");
    step(1, 32'h40000001, 32'hBFC00304, 0, 0, 0, "rst_fill1");
    step(1, 32'h40000002, 32'hBFC00308, 0, 0, 0, "rst_fill2");
    @(negedge clk);
    drive(1, 32'h40000003, 32'hBFC0030C, 0, 0, 1);
    #1;
    cmp32("rst_pre_cnt", 32'(count), 32'd3);
    #1;
    resetn = 1'b0;
    #1;
    cmp("rst_async", obs(), {3'd0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0});
    q.delete();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    step(0, 0, 0, 0, 0, 0, "rst_after");

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 32'h80000000 | (32'($urandom_range(0, 16'hFFFF)) << 2),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 2) != 0), $sformatf("rand%0d", i));
    end

    n_vec++;
    if (seen_flushed) begin
      n_err++;
      $display("FAIL flushed_word: got pc BFC00100 on pcD want never shown");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction queue between the AXI instruction-fetch stage and the ID-stage main decoder.
- Buffers fetched words with their PC and fetch-exception flag, and presents the head entry to decode.
- Drives the decoder's stall input while no instruction is available.
- Absorbs fetch-latency jitter and is emptied by branch/exception flush.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
PTR_W, 2, pointer width, log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  fetch stage presents a word
in_ready  output  1  queue can accept a word this cycle
in_instr  input  32  fetched instruction word
in_pc  input  32  PC of fetched word
in_adel  input  1  fetch address error for this word
flush  input  1  discard all buffered and incoming words (branch redirect / exception)
id_accept  input  1  ID stage consumes head entry this cycle (pipeline not stalled downstream)
instrD  output  32  head instruction to decoder
pcD  output  32  head PC
adelD  output  1  head fetch-exception flag
validD  output  1  head entry valid
stallD  output  1  to decoder: high when validD is low
count  output  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of {instr, pc, adel}; wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH); occupancy counter PTR_W+1 bits.
- Push: in_valid & in_ready & ~flush. Write entry at wr_ptr, wr_ptr+1.
- Pop: id_accept & validD & ~flush. rd_ptr+1. id_accept while validD=0 is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- in_ready = (count != DEPTH). No push-through when full; a full queue with id_accept still reports in_ready=0 that cycle.
- Head outputs are combinational from mem[rd_ptr] when count!=0.
- When empty: instrD=32'h0 (NOP), pcD=0, adelD=0, validD=0, stallD=1.
- Latency: a word pushed at edge N is visible on instrD after edge N+1 (one-cycle minimum).
- Flush has priority over push and pop. At the next edge, pointers and count return to 0.
  - A word handshaken in the flush cycle counts as consumed by fetch and is dropped.
  - During the flush cycle itself, outputs still reflect the pre-flush head.
- Reset: asynchronous on resetn low. Pointers and count cleared, so in_ready=1, validD=0, stallD=1, instrD=0, pcD=0, adelD=0, count=0. Entry contents are don't-care.
- Reset asserted mid-transfer aborts it; no partial entry survives.
- Overflow and underflow are impossible by construction. The bench asserts count never exceeds DEPTH.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count==0 and in_valid and ~flush, the input word drives instrD/pcD/adelD with validD=1 and stallD=0 in the same cycle.
  - With id_accept also high, the word is consumed without being written (count stays 0).
  - Otherwise it is written normally.
- Undefined: no bypass; strict one-cycle latency as above.

Test Plan:
- Reset then idle -> in_ready=1, validD=0, stallD=1, instrD=0x00000000, count=0.
- Push 0x3C011234@pc 0xBFC00000 and 0x34210001@0xBFC00004 with id_accept=0 -> count=2; instrD=0x3C011234, pcD=0xBFC00000; one id_accept pulse -> instrD=0x34210001, pcD=0xBFC00004, count=1.
- Push 4 words without accepting -> count=4, in_ready=0; a 5th in_valid is not taken; one id_accept -> in_ready=1 next cycle, head is word 2.
- Continuous push and accept for 10 cycles starting at count=2 -> count stays 2, pointers wrap, output PCs strictly sequential by +4.
- count=3 plus flush with in_valid=1 (pc 0xBFC00100) -> next cycle count=0, validD=0, stallD=1; the pc 0xBFC00100 word never appears on pcD.
- Push word with in_adel=1 at pc 0xBFC00002 -> adelD=1, pcD=0xBFC00002 when at head. resetn low mid-stream with count=3 -> immediately count=0, validD=0.
